// File: rtl/serial_det_pkg.sv
// Shared state encoding and width helpers for the serial detector arbiter.
// No timing of its own; holds no state.
package serial_det_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    function automatic int idw_of(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // Hit counter must hold 0..WIDTH inclusive.
    function automatic int cw_of(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_det_arbiter_rr.sv
// Round-robin pick: first set request at or after i_ptr, wrapping; purely combinational.
// Latency 0; nothing is granted while i_en is low.
module rr_arbiter
    import serial_det_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = idw_of(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_winner
);

    logic w_found;
    int   w_idx;

    always_comb begin
        o_gnt    = '0;
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NREQ;
            if (!w_found && i_en && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_winner     = IDW'(w_idx);
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_det_arbiter.sv
// Shares one serial detector among NREQ requesters: grant, clear, shift MSB first, count z, report.
// Latency gnt->done WIDTH+3 cycles; requests are simply held off (no gnt) while busy.
module serial_det_arbiter
    import serial_det_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = idw_of(NREQ),
    parameter int CW    = cw_of(WIDTH)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ*WIDTH-1:0]   i_data,
    output logic [NREQ-1:0]         o_gnt,
    output logic                    o_det_x,
    output logic                    o_det_rst,
    input  logic                    i_det_z,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [IDW-1:0]          o_done_id,
    output logic [CW-1:0]           o_hits
);

    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state, w_state_nxt;
    logic [NREQ-1:0]    w_gnt;
    logic [IDW-1:0]     w_winner;
    logic               w_arb_en;
    logic               w_grant;
    logic [WIDTH-1:0]   r_shreg;
    logic [BCW-1:0]     r_bit_cnt;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_id;
    logic               r_sent;
    logic [CW-1:0]      r_hit_cnt;
    logic [CW-1:0]      w_hit_nxt;
    logic [IDW-1:0]     r_done_id;
    logic [CW-1:0]      r_hits;

    // Gating with reset keeps gnt low while reset is held, even with requests pending.
    assign w_arb_en = (r_state == ST_IDLE) && i_rst;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .i_en     (w_arb_en),
        .o_gnt    (w_gnt),
        .o_winner (w_winner)
    );

    assign w_grant   = |w_gnt;
    assign w_hit_nxt = r_hit_cnt + CW'(r_sent & i_det_z);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_grant) w_state_nxt = ST_CLEAR;
            ST_CLEAR:  w_state_nxt = ST_SHIFT;
            ST_SHIFT:  if (r_bit_cnt == '0) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  w_state_nxt = ST_REPORT;
            ST_REPORT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // r_sent marks cycles whose det_z reflects a bit shifted out the cycle before.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_ptr     <= '0;
            r_id      <= '0;
            r_sent    <= 1'b0;
            r_hit_cnt <= '0;
            r_done_id <= '0;
            r_hits    <= '0;
        end else begin
            r_sent <= (r_state == ST_SHIFT);
            if (w_grant) begin
                r_shreg   <= i_data[int'(w_winner)*WIDTH +: WIDTH];
                r_bit_cnt <= BCW'(WIDTH - 1);
                r_ptr     <= (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + 1'b1;
                r_id      <= w_winner;
                r_hit_cnt <= '0;
            end else begin
                r_hit_cnt <= w_hit_nxt;
            end
            if (r_state == ST_SHIFT) begin
                r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt - 1'b1;
            end
            if (r_state == ST_DRAIN) begin
                r_hits    <= w_hit_nxt;
                r_done_id <= r_id;
            end
        end
    end

    assign o_gnt     = w_gnt;
    assign o_det_x   = (r_state == ST_SHIFT) && r_shreg[WIDTH-1];
    assign o_det_rst = (r_state == ST_CLEAR);
    assign o_busy    = (r_state != ST_IDLE);
    assign o_done    = (r_state == ST_REPORT);
    assign o_done_id = r_done_id;
    assign o_hits    = r_hits;

endmodule

// File: tb/tb_serial_det_arbiter.sv
// Directed bench for serial_det_arbiter with a stub detector (z <= rst ? z : x).
module tb_serial_det_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;
    localparam int CW    = 4;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       gnt;
    logic                  det_x;
    logic                  det_rst;
    logic                  det_z;
    logic                  busy;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic [CW-1:0]         hits;

    int n_err;
    int n_checks;

    serial_det_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .CW(CW)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_data    (data),
        .o_gnt     (gnt),
        .o_det_x   (det_x),
        .o_det_rst (det_rst),
        .i_det_z   (det_z),
        .o_busy    (busy),
        .o_done    (done),
        .o_done_id (done_id),
        .o_hits    (hits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) det_z <= 1'b0;
        else      det_z <= det_rst ? det_z : det_x;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in an IDLE cycle; requests lane id, follows the whole sequence to done.
    task automatic run_word(input string tag, input int id, input logic [WIDTH-1:0] w,
                            input int exp_hits);
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        req = oh;
        data[id*WIDTH +: WIDTH] = w;
        #1;
        chk({tag, ".gnt"}, 32'(gnt), 32'(oh));
        tick();
        req = '0;
        #1;
        chk({tag, ".clear_rst"}, 32'(det_rst), 1);
        chk({tag, ".clear_x"}, 32'(det_x), 0);
        for (int b = 0; b < WIDTH; b++) begin
            tick();
            #1;
            chk({tag, ".shift_x"}, 32'(det_x), 32'(w[WIDTH-1-b]));
            if (b == 0) chk({tag, ".shift_rst"}, 32'(det_rst), 0);
        end
        tick();
        #1;
        chk({tag, ".drain_x"}, 32'(det_x), 0);
        chk({tag, ".drain_done"}, 32'(done), 0);
        tick();
        #1;
        chk({tag, ".done"}, 32'(done), 1);
        chk({tag, ".done_id"}, 32'(done_id), 32'(id));
        chk({tag, ".hits"}, 32'(hits), 32'(exp_hits));
        tick();
        #1;
        chk({tag, ".done_low"}, 32'(done), 0);
        chk({tag, ".idle"}, 32'(busy), 0);
        chk({tag, ".hits_held"}, 32'(hits), 32'(exp_hits));
    endtask

    task automatic wait_done(input string tag, input int exp_id, input int exp_hits);
        int found;
        found = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (done) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #0;
        end
        chk({tag, ".done_seen"}, 32'(found), 1);
        chk({tag, ".done_id"}, 32'(done_id), 32'(exp_id));
        chk({tag, ".hits"}, 32'(hits), 32'(exp_hits));
    endtask

    logic [NREQ-1:0] g_seq [5];
    int              g_cyc [5];
    logic [IDW-1:0]  d_id  [5];
    logic [CW-1:0]   d_hit [5];
    int              ng;
    int              nd;
    int              bad;

    initial begin
        n_err = 0;
        n_checks = 0;
        rst  = 1'b0;
        req  = '0;
        data = '0;
        #3;
        chk("rst.gnt", 32'(gnt), 0);
        chk("rst.det_x", 32'(det_x), 0);
        chk("rst.det_rst", 32'(det_rst), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.done_id", 32'(done_id), 0);
        chk("rst.hits", 32'(hits), 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // All requesting: order 0,1,2,3,0 every WIDTH+4 cycles; lane i scores i+1 hits.
        ng = 0;
        nd = 0;
        data = {8'h0F, 8'h07, 8'h03, 8'h01};
        req = '1;
        for (int c = 0; c < 80 && nd < 5; c++) begin
            if (c > 0) tick();
            if (ng == 5) req = '0;
            #1;
            if (gnt != '0 && ng < 5) begin
                g_seq[ng] = gnt;
                g_cyc[ng] = c;
                ng++;
            end
            if (done) begin
                if (nd < 5) begin
                    d_id[nd]  = done_id;
                    d_hit[nd] = hits;
                end
                nd++;
            end
        end
        chk("rr.grants", 32'(ng), 5);
        chk("rr.dones", 32'(nd), 5);
        for (int i = 0; i < 5; i++) begin
            chk("rr.gnt_order", 32'(g_seq[i]), 32'(1 << (i % 4)));
            chk("rr.done_id", 32'(d_id[i]), 32'(i % 4));
            chk("rr.hits", 32'(d_hit[i]), 32'((i % 4) + 1));
            if (i > 0) chk("rr.spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'(WIDTH + 4));
        end
        tick();
        data = '0;

        run_word("a5", 2, 8'hA5, 4);

        // Stub echoes x, so an all-ones word scores WIDTH.
        run_word("zero_a", 0, 8'h00, 0);
        run_word("ones_a", 1, 8'hFF, 8);

        // z is left at 1 from the ones word; it must not leak into the next count.
        run_word("ones_b", 2, 8'hFF, 8);
        run_word("stale", 3, 8'h00, 0);

        // A request raised mid-word waits until the engine returns to IDLE.
        req = 4'b0001;
        data[7:0] = 8'h3C;
        #1;
        chk("busy_req.gnt0", 32'(gnt), 32'b0001);
        tick();
        req = '0;
        tick();
        tick();
        bad = 0;
        for (int c = 3; c <= 11; c++) begin
            if (c == 3) begin
                req = 4'b0010;
                data[15:8] = 8'hC3;
            end
            #1;
            if (gnt != '0) bad++;
            if (c == 11) begin
                chk("busy_req.done", 32'(done), 1);
                chk("busy_req.done_id", 32'(done_id), 0);
                chk("busy_req.hits", 32'(hits), 4);
            end
            tick();
        end
        chk("busy_req.no_gnt", 32'(bad), 0);
        #1;
        chk("busy_req.gnt1", 32'(gnt), 32'b0010);
        tick();
        req = '0;
        wait_done("busy_req.w1", 1, 4);
        tick();

        // Reset mid-SHIFT abandons the word; no done, then a clean fresh sequence.
        req = 4'b0001;
        data[7:0] = 8'hFF;
        #1;
        chk("abort.gnt", 32'(gnt), 32'b0001);
        tick();
        req = '0;
        tick();
        tick();
        tick();
        tick();
        #1;
        chk("abort.busy_pre", 32'(busy), 1);
        rst = 1'b0;
        req = 4'b1000;
        #1;
        chk("abort.gnt", 32'(gnt), 0);
        chk("abort.det_x", 32'(det_x), 0);
        chk("abort.det_rst", 32'(det_rst), 0);
        chk("abort.busy", 32'(busy), 0);
        chk("abort.done", 32'(done), 0);
        chk("abort.done_id", 32'(done_id), 0);
        chk("abort.hits", 32'(hits), 0);
        tick();
        #1;
        chk("abort.done_hold", 32'(done), 0);
        tick();
        req = '0;
        rst = 1'b1;
        #1;
        chk("abort.idle", 32'(busy), 0);
        tick();
        run_word("fresh", 3, 8'h96, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
